// File: rtl/moore_event_logger.sv
`default_nettype none
// ============================================================================
// Module      : moore_event_logger
// Description : Timestamps the events flagged by an upstream 1010 Moore
//               detector. Each cycle with det_in high is one event. The event
//               pushes the current free-running timestamp into a small
//               first-word-fall-through FIFO. The block also keeps a
//               saturating event counter and a sticky overflow flag. An
//               optional counter of dropped events can be built in.
//
// Ports       : clk        - single clock, rising edge
//               reset      - synchronous active-high reset (highest priority)
//               det_in     - event strobe, one event per high cycle
//               clr        - synchronous soft clear of the log state
//                            (the timestamp keeps running)
//               evt_ready  - consumer takes the head entry this cycle
//               evt_valid  - FIFO non-empty, head entry on evt_ts
//               evt_ts     - timestamp of head entry (FWFT)
//               evt_count  - events since reset/clr, saturating
//               fifo_full  - FIFO holds DEPTH entries
//               overflow   - sticky, an event was dropped while full
//               drop_cnt   - dropped-event count, saturating at 15
//                            (only with DROP_CNT_EN)
//
// Parameters  : DEPTH - FIFO entries, power of two in 2..16
//               TS_W  - timestamp / event-count width
// Macros      : DROP_CNT_EN - adds the drop_cnt port and its counter
//
// Revision    : 1.0 - initial release
// ============================================================================
module moore_event_logger #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TS_W  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            det_in,
    input  logic            clr,
    input  logic            evt_ready,
    output logic            evt_valid,
    output logic [TS_W-1:0] evt_ts,
    output logic [TS_W-1:0] evt_count,
    output logic            fifo_full,
    output logic            overflow
`ifdef DROP_CNT_EN
    ,
    output logic [3:0]      drop_cnt
`endif
);

    localparam int unsigned     c_ADDR_W = $clog2(DEPTH);
    localparam int unsigned     c_OCC_W  = c_ADDR_W + 1;
    localparam logic [c_OCC_W-1:0] c_DEPTH = c_OCC_W'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TS_W-1:0]     ts_q,        ts_d;
    logic [c_ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [c_ADDR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic [c_OCC_W-1:0]  occ_q,       occ_d;
    logic [TS_W-1:0]     evt_count_q, evt_count_d;
    logic                overflow_q,  overflow_d;
    logic [TS_W-1:0]     mem_q [DEPTH];

    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_mem_we;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    // A pop in the same cycle frees the head slot, so a full FIFO still
    // accepts a new event when the consumer is reading.
    assign w_full   = (occ_q == c_DEPTH);
    assign w_pop    = (occ_q != '0) && evt_ready;
    assign w_push   = det_in && (!w_full || w_pop);
    assign w_drop   = det_in && w_full && !w_pop;
    assign w_mem_we = w_push && !clr && !reset;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        ts_d        = ts_q + 1'b1;   // wraps naturally at all-ones
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        evt_count_d = evt_count_q;
        overflow_d  = overflow_q;

        if (clr) begin
            // The event and the pop that arrive with clr are both discarded.
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            occ_d       = '0;
            evt_count_d = '0;
            overflow_d  = 1'b0;
        end else begin
            // Pointers wrap modulo DEPTH because DEPTH is a power of two.
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end

            unique case ({w_push, w_pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase

            // Count every event, including dropped ones.
            if (det_in && (evt_count_q != {TS_W{1'b1}})) begin
                evt_count_d = evt_count_q + 1'b1;
            end

            if (w_drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            evt_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            ts_q        <= ts_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            evt_count_q <= evt_count_d;
            overflow_q  <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Timestamp storage. No reset is needed: the stored data is unused
    // until a write has made the FIFO non-empty.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[wr_ptr_q] <= ts_q;
        end
    end

    // ------------------------------------------------------------------
    // Optional dropped-event counter
    // ------------------------------------------------------------------
`ifdef DROP_CNT_EN
    logic [3:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clr) begin
            drop_cnt_d = '0;
        end else if (w_drop && (drop_cnt_q != 4'hF)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign evt_valid = (occ_q != '0);
    assign evt_ts    = mem_q[rd_ptr_q];
    assign evt_count = evt_count_q;
    assign fifo_full = w_full;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_moore_event_logger.sv
`default_nettype none
// ============================================================================
// Module      : tb_moore_event_logger
// Description : Self-checking bench for moore_event_logger with the default
//               parameters (DEPTH=4, TS_W=8). It uses a table of directed
//               vectors and hand-written sequences for timestamp wrap and
//               counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_moore_event_logger;

    logic       clk;
    logic       reset;
    logic       det_in;
    logic       clr;
    logic       evt_ready;
    logic       evt_valid;
    logic [7:0] evt_ts;
    logic [7:0] evt_count;
    logic       fifo_full;
    logic       overflow;
`ifdef DROP_CNT_EN
    logic [3:0] drop_cnt;
`endif

    int n_checks;
    int n_errors;

    moore_event_logger #(
        .DEPTH (4),
        .TS_W  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .det_in    (det_in),
        .clr       (clr),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_ts    (evt_ts),
        .evt_count (evt_count),
        .fifo_full (fifo_full),
        .overflow  (overflow)
`ifdef DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       clr;
        logic       det;
        logic       rdy;
        logic       e_valid;
        logic       chk_ts;
        logic [7:0] e_ts;
        logic [7:0] e_cnt;
        logic       e_full;
        logic       e_ov;
        logic [3:0] e_drop;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic c, input logic d, input logic y,
                       input logic v, input logic ct, input int ts, input int cnt,
                       input logic f, input logic ov, input int dr);
        vec_t t;
        t.rst = r; t.clr = c; t.det = d; t.rdy = y;
        t.e_valid = v; t.chk_ts = ct; t.e_ts = 8'(ts); t.e_cnt = 8'(cnt);
        t.e_full = f; t.e_ov = ov; t.e_drop = 4'(dr);
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample 1 ns after the rising edge.
    task automatic step(input logic r, input logic c, input logic d, input logic y);
        @(negedge clk);
        reset = r; clr = c; det_in = d; evt_ready = y;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string tag, input vec_t t);
        check({tag, ".valid"}, int'(evt_valid), int'(t.e_valid));
        if (t.e_valid && t.chk_ts)
            check({tag, ".ts"}, int'(evt_ts), int'(t.e_ts));
        check({tag, ".count"}, int'(evt_count), int'(t.e_cnt));
        check({tag, ".full"}, int'(fifo_full), int'(t.e_full));
        check({tag, ".overflow"}, int'(overflow), int'(t.e_ov));
`ifdef DROP_CNT_EN
        check({tag, ".drop"}, int'(drop_cnt), int'(t.e_drop));
`endif
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        clr       = 1'b0;
        det_in    = 1'b0;
        evt_ready = 1'b0;

        // Fields: rst clr det rdy | valid chk_ts ts cnt full ov drop
        // The comment on each row gives the timestamp of the cycle in which the row is applied.
        // --- single event at ts=3, then pop, then ready while empty
        add(1,0,0,0, 0,0,0, 0,0,0,0);            // reset
        add(0,0,0,0, 0,0,0, 0,0,0,0);            // ts0
        add(0,0,0,0, 0,0,0, 0,0,0,0);            // ts1
        add(0,0,0,0, 0,0,0, 0,0,0,0);            // ts2
        add(0,0,1,0, 1,1,3, 1,0,0,0);            // ts3 event
        add(0,0,0,0, 1,1,3, 1,0,0,0);            // ts4 held
        add(0,0,0,1, 0,0,0, 1,0,0,0);            // ts5 pop
        add(0,0,0,1, 0,0,0, 1,0,0,0);            // ts6 ready ignored
        // --- events 2,4,6,8,10 with no reads: fill, overflow, drain, clear
        add(1,0,0,0, 0,0,0, 0,0,0,0);            // reset
        add(0,0,0,0, 0,0,0, 0,0,0,0);            // ts0
        add(0,0,0,0, 0,0,0, 0,0,0,0);            // ts1
        add(0,0,1,0, 1,1,2, 1,0,0,0);            // ts2
        add(0,0,0,0, 1,1,2, 1,0,0,0);            // ts3
        add(0,0,1,0, 1,1,2, 2,0,0,0);            // ts4
        add(0,0,0,0, 1,1,2, 2,0,0,0);            // ts5
        add(0,0,1,0, 1,1,2, 3,0,0,0);            // ts6
        add(0,0,0,0, 1,1,2, 3,0,0,0);            // ts7
        add(0,0,1,0, 1,1,2, 4,1,0,0);            // ts8 full
        add(0,0,0,0, 1,1,2, 4,1,0,0);            // ts9
        add(0,0,1,0, 1,1,2, 5,1,1,1);            // ts10 dropped
        add(0,0,0,0, 1,1,2, 5,1,1,1);            // ts11 sticky
        add(0,0,0,1, 1,1,4, 5,0,1,1);            // ts12 pop 2
        add(0,0,0,1, 1,1,6, 5,0,1,1);            // ts13 pop 4
        add(0,0,0,1, 1,1,8, 5,0,1,1);            // ts14 pop 6
        add(0,0,0,1, 0,0,0, 5,0,1,1);            // ts15 pop 8, ts10 absent
        add(0,1,0,0, 0,0,0, 0,0,0,0);            // ts16 clr
        add(0,0,1,0, 1,1,17, 1,0,0,0);           // ts17 ts kept running
        // --- det during reset ignored; push+pop while full
        add(1,0,1,0, 0,0,0, 0,0,0,0);            // reset with det
        add(0,0,1,0, 1,1,0, 1,0,0,0);            // ts0
        add(0,0,1,0, 1,1,0, 2,0,0,0);            // ts1
        add(0,0,1,0, 1,1,0, 3,0,0,0);            // ts2
        add(0,0,1,0, 1,1,0, 4,1,0,0);            // ts3 full
        add(0,0,1,1, 1,1,1, 5,1,0,0);            // ts4 push+pop while full
        add(0,0,0,1, 1,1,2, 5,0,0,0);            // ts5
        add(0,0,0,1, 1,1,3, 5,0,0,0);            // ts6
        add(0,0,0,1, 1,1,4, 5,0,0,0);            // ts7
        add(0,0,0,1, 0,0,0, 5,0,0,0);            // ts8 empty
        // --- clr with 3 queued, det and ready in the same cycle
        add(1,0,0,0, 0,0,0, 0,0,0,0);            // reset
        add(0,0,1,0, 1,1,0, 1,0,0,0);            // ts0
        add(0,0,1,0, 1,1,0, 2,0,0,0);            // ts1
        add(0,0,1,0, 1,1,0, 3,0,0,0);            // ts2
        add(0,1,1,1, 0,0,0, 0,0,0,0);            // ts3 clr
        add(0,0,1,0, 1,1,4, 1,0,0,0);            // ts4
        add(1,0,0,0, 0,0,0, 0,0,0,0);            // reset mid-operation
        add(0,0,0,0, 0,0,0, 0,0,0,0);            // ts0

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].clr, vecs[i].det, vecs[i].rdy);
            check_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // --- timestamp wrap: events at ts=254 and ts=1
        step(1, 0, 0, 0);
        for (int i = 0; i < 254; i++) step(0, 0, 0, 0);   // ts0..ts253
        step(0, 0, 1, 0);                                 // ts254 event
        check("wrap.valid0", int'(evt_valid), 1);
        check("wrap.ts254", int'(evt_ts), 254);
        step(0, 0, 0, 0);                                 // ts255
        step(0, 0, 0, 0);                                 // ts0
        step(0, 0, 1, 0);                                 // ts1 event
        check("wrap.count", int'(evt_count), 2);
        check("wrap.head", int'(evt_ts), 254);
        step(0, 0, 0, 1);                                 // pop 254
        check("wrap.valid1", int'(evt_valid), 1);
        check("wrap.ts1", int'(evt_ts), 1);
        step(0, 0, 0, 1);                                 // pop 1
        check("wrap.empty", int'(evt_valid), 0);

        // --- event counter saturation with continuous reads
        step(1, 0, 0, 0);
        for (int i = 0; i < 255; i++) step(0, 0, 1, 1);   // events at ts0..ts254
        check("sat.count255", int'(evt_count), 255);
        check("sat.ov_a", int'(overflow), 0);
        step(0, 0, 1, 1);                                 // 256th event at ts255
        check("sat.count_hold", int'(evt_count), 255);
        check("sat.ov_b", int'(overflow), 0);
        check("sat.valid", int'(evt_valid), 1);
        check("sat.head", int'(evt_ts), 255);
        check("sat.full", int'(fifo_full), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/moore_event_logger.md
MOORE_EVENT_LOGGER -- requirements
Module: moore_event_logger

Interface
REQ-001 Parameter DEPTH, default 4, timestamp FIFO entries; power of two, 2..16.
REQ-002 Parameter TS_W, default 8, timestamp and event-count width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 det_in  input  1  detection output of the upstream 1010 Moore detector; each cycle sampled high is one event.
REQ-006 clr  input  1  synchronous soft clear of log state.
REQ-007 evt_ready  input  1  consumer accepts head entry this cycle.
REQ-008 evt_valid  output  1  FIFO non-empty; head entry presented.
REQ-009 evt_ts  output  TS_W  timestamp of head entry; first-word-fall-through.
REQ-010 evt_count  output  TS_W  total events seen since reset/clr, saturating.
REQ-011 fifo_full  output  1  FIFO holds DEPTH entries.
REQ-012 overflow  output  1  sticky: an event was dropped because the FIFO was full.
REQ-013 drop_cnt  output  4  dropped-event count; present only with DROP_CNT_EN.

Function
REQ-014 Free-running timestamp ts (TS_W bits) increments every cycle, wraps all-ones -> 0; unaffected by clr.
REQ-015 Event in cycle N (det_in=1 at edge N) pushes the ts value of cycle N; evt_valid high from cycle N+1, evt_ts equal to that value (1-cycle latency).
REQ-016 Back-to-back events (det_in high consecutive cycles) each push one entry; no edge detection.
REQ-017 Pop occurs when evt_valid && evt_ready; evt_ready with evt_valid low is ignored.
REQ-018 Entries leave in push order; evt_ts stable while evt_valid && !evt_ready.
REQ-019 Push and pop in same cycle: both performed; occupancy unchanged; legal when full (push accepted, no drop).
REQ-020 Event while full and no pop: entry discarded, overflow set to 1 next cycle, stays until reset/clr.
REQ-021 evt_count increments on every event (accepted or dropped); saturates at all-ones, no wrap.
REQ-022 Pointers wrap modulo DEPTH; fifo_full = occupancy==DEPTH; evt_valid = occupancy!=0.
REQ-023 clr=1: FIFO emptied, evt_count=0, overflow=0, drop_cnt=0 next cycle; event and pop in the clr cycle discarded.
REQ-024 evt_ts when evt_valid=0 is don't-care; bench shall not check it.

Reset
REQ-025 reset=1 at an edge: ts=0, FIFO empty, evt_valid=0, fifo_full=0, evt_count=0, overflow=0, drop_cnt=0.
REQ-026 reset has priority over clr, det_in, evt_ready; det_in during reset not logged.
REQ-027 Reset mid-operation discards all queued entries; first cycle after reset release has ts=0.

Configuration
REQ-028 Macro DROP_CNT_EN defined: drop_cnt port exists, increments per dropped event, saturates at 15, cleared by reset/clr.
REQ-029 DROP_CNT_EN undefined: drop_cnt port and counter absent; all other behaviour identical.

Verification
REQ-030 Reset 1 cycle, det_in high at ts=3 only, evt_ready=0 -> evt_valid=1 from ts=4, evt_ts=3, evt_count=1.
REQ-031 Events at ts=2,4,6,8,10 (overlapping 1010 pattern), evt_ready=0, DEPTH=4 -> fifo_full after ts=8 event, ts=10 dropped, overflow=1, evt_count=5, drop_cnt=1 (macro on).
REQ-032 Full FIFO, event and evt_ready=1 same cycle -> head popped, new entry queued, overflow stays 0, fifo_full stays 1.
REQ-033 Event at ts=254 and ts=1 (after wrap) -> popped timestamps 254 then 1.
REQ-034 Queue 3 entries, assert clr with det_in=1 -> next cycle evt_valid=0, evt_count=0, overflow=0, ts keeps counting.
REQ-035 Force 256 events with continuous evt_ready=1 -> evt_count holds 255, overflow=0.
